// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-16 sequential demultiplexer.
package demux_pkg;

  localparam int DEMUX_WIDTH = 16;
  localparam int DEMUX_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/demux_1_to_16_seq_if.sv
// Data/control bundle between the bit source (master) and the demux (slave).
interface demux_1_to_16_seq_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int SEL_W = DEMUX_SEL_W
);

  logic             din;
  logic [SEL_W-1:0] sel;
  logic             wr_en;
  logic             auto_mode;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             parity_err;

  modport master (
    output din, sel, wr_en, auto_mode, start,
    input  dout, busy, done, out_valid, parity_err
  );

  modport slave (
    input  din, sel, wr_en, auto_mode, start,
    output dout, busy, done, out_valid, parity_err
  );

endinterface

// File: rtl/demux_bit_counter.sv
// Bit-position counter for frame assembly: clear has priority over enable,
// wraps naturally, and flags the last position of the word.
module demux_bit_counter #(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [SEL_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = &r_cnt;

endmodule

// File: rtl/demux_1_to_16_seq.sv
// Registered 1-to-16 demux/deserializer with addressed and auto-frame modes.
// Define PARITY_CHECK_EN to add a trailing even-parity bit check per frame.
module demux_1_to_16_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int SEL_W = DEMUX_SEL_W
) (
  input logic                 clk,
  input logic                 rst_n,
  demux_1_to_16_seq_if.slave  bus
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_dout;
  logic             r_out_valid;
  logic [SEL_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_wr;
  logic [SEL_W-1:0] w_idx;
  logic             w_ov_set;
  logic             w_ov_clr;
`ifdef PARITY_CHECK_EN
  logic             r_parity_err;
  logic             w_perr_set;
  logic             w_perr_clr;
`endif

  demux_bit_counter #(.SEL_W(SEL_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_en   = 1'b0;
    w_wr       = 1'b0;
    w_idx      = bus.sel;
    w_ov_set   = 1'b0;
    w_ov_clr   = 1'b0;
`ifdef PARITY_CHECK_EN
    w_perr_set = 1'b0;
    w_perr_clr = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        // A start outranks a simultaneous wr_en; that din is dropped.
        if (bus.auto_mode) begin
          if (bus.start) begin
            w_next    = ST_SHIFT;
            w_cnt_clr = 1'b1;
            w_ov_clr  = 1'b1;
`ifdef PARITY_CHECK_EN
            w_perr_clr = 1'b1;
`endif
          end
        end else if (bus.wr_en) begin
          w_wr     = 1'b1;
          w_ov_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_idx = w_cnt;
        if (!bus.auto_mode) begin
          w_next    = ST_IDLE;
          w_cnt_clr = 1'b1;
        end else if (bus.wr_en) begin
          w_wr     = 1'b1;
          w_cnt_en = 1'b1;
          if (w_tc) begin
`ifdef PARITY_CHECK_EN
            w_next = ST_PAR;
`else
            w_next = ST_DONE;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PAR: begin
        // Even parity: the extra bit must equal the XOR of the data bits.
        if (!bus.auto_mode) begin
          w_next    = ST_IDLE;
          w_cnt_clr = 1'b1;
        end else if (bus.wr_en) begin
          w_perr_set = (bus.din != ^r_dout);
          w_next     = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        w_next = ST_IDLE;
`ifdef PARITY_CHECK_EN
        w_ov_set = !r_parity_err;
`else
        w_ov_set = 1'b1;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr)          r_dout[w_idx] <= bus.din;
      if (w_ov_clr)      r_out_valid   <= 1'b0;
      else if (w_ov_set) r_out_valid   <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_parity_err <= 1'b0;
    else if (w_perr_clr) r_parity_err <= 1'b0;
    else if (w_perr_set) r_parity_err <= 1'b1;
  end
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.dout      = r_dout;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_SHIFT) || (r_state == ST_PAR);

endmodule
